buffer_fifo: RTL and testbench

BUFFER_FIFO -- requirements
Module: buffer_fifo

---
 rtl/buffer_fifo.sv | 90 +++++++++
 tb/tb_buffer_fifo.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/buffer_fifo.sv
// buffer_fifo: single-clock circular FIFO with registered read data,
// occupancy counter, almost-full flag and one-cycle error pulses for
// rejected write/read requests. Storage is not reset; the pointers and
// counter are, so no stale entry is ever readable after reset.
module buffer_fifo #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wrEnable,
  input  logic                     rdEnable,
  input  logic [WIDTH-1:0]         dataIn,
  output logic [WIDTH-1:0]         dataOut,
  output logic                     rdValid,
  output logic                     full,
  output logic                     empty,
  output logic                     almostFull,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     wrError,
  output logic                     rdError
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic             rdAcc;
  logic             wrAcc;
  logic [CW-1:0]    countNext;

  // Status flags decode the count register only, never same-cycle requests.
  always_comb begin
    full       = (count == CW'(DEPTH));
    empty      = (count == {CW{1'b0}});
    almostFull = (count >= CW'(AF_LEVEL));
  end

  // Request acceptance: a write while full is taken only alongside an accepted read.
  always_comb begin
    rdAcc = rdEnable & ~empty;
    wrAcc = wrEnable & (~full | rdAcc);
  end

  // Next occupancy: simultaneous accepted read and write leave it unchanged.
  always_comb begin
    countNext = count;
    case ({wrAcc, rdAcc})
      2'b10:   countNext = count + CW'(1);
      2'b01:   countNext = count - CW'(1);
      default: countNext = count;
    endcase
  end

  // Storage array: written on an accepted write, deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wrAcc && !reset) begin
      mem[wrPtr] <= dataIn;
    end
  end

  // Pointers, occupancy, read data and status pulses with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr   <= {PW{1'b0}};
      rdPtr   <= {PW{1'b0}};
      count   <= {CW{1'b0}};
      dataOut <= {WIDTH{1'b0}};
      rdValid <= 1'b0;
      wrError <= 1'b0;
      rdError <= 1'b0;
    end else begin
      if (wrAcc) begin
        wrPtr <= wrPtr + PW'(1);
      end
      if (rdAcc) begin
        rdPtr   <= rdPtr + PW'(1);
        dataOut <= mem[rdPtr];
      end
      count   <= countNext;
      rdValid <= rdAcc;
      wrError <= wrEnable & ~wrAcc;
      rdError <= rdEnable & ~rdAcc;
    end
  end

endmodule

// File: tb/tb_buffer_fifo.sv
// tb_buffer_fifo: directed vector table, asynchronous reset sequence and
// randomized traffic checked against a queue-based reference model.
module tb_buffer_fifo;

  localparam int WIDTH = 64;
  localparam int DEPTH = 4;
  localparam int AFL   = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             wrEnable = 1'b0;
  logic             rdEnable = 1'b0;
  logic [WIDTH-1:0] dataIn = '0;
  logic [WIDTH-1:0] dataOut;
  logic             rdValid, full, empty, almostFull, wrError, rdError;
  logic [2:0]       count;

  int nChecks = 0;
  int nFails  = 0;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [63:0] din;
    logic [63:0] eData;
    int          eCount;
    logic        eValid;
    logic        eWrErr;
    logic        eRdErr;
  } vec_t;

  vec_t vecs[$];

  logic [63:0] modelQ[$];
  logic [63:0] modelData;

  buffer_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AFL)) dut (
    .clk(clk), .reset(reset), .wrEnable(wrEnable), .rdEnable(rdEnable),
    .dataIn(dataIn), .dataOut(dataOut), .rdValid(rdValid), .full(full),
    .empty(empty), .almostFull(almostFull), .count(count),
    .wrError(wrError), .rdError(rdError)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Check all outputs against an expected occupancy and pulse set.
  task automatic chkAll(input string tag, input logic [63:0] eData, input int eCount,
                        input logic eValid, input logic eWrErr, input logic eRdErr);
    chk({tag, ".dataOut"}, dataOut, eData);
    chk({tag, ".count"}, 64'(count), 64'(eCount));
    chk({tag, ".rdValid"}, 64'(rdValid), 64'(eValid));
    chk({tag, ".wrError"}, 64'(wrError), 64'(eWrErr));
    chk({tag, ".rdError"}, 64'(rdError), 64'(eRdErr));
    chk({tag, ".full"}, 64'(full), 64'(eCount == DEPTH));
    chk({tag, ".empty"}, 64'(empty), 64'(eCount == 0));
    chk({tag, ".almostFull"}, 64'(almostFull), 64'(eCount >= AFL));
  endtask

  task automatic step(input logic wr, input logic rd, input logic [63:0] din);
    wrEnable = wr;
    rdEnable = rd;
    dataIn   = din;
    @(posedge clk);
    #1;
    wrEnable = 1'b0;
    rdEnable = 1'b0;
  endtask

  task automatic addVec(input logic wr, input logic rd, input logic [63:0] din,
                        input logic [63:0] eData, input int eCount,
                        input logic eValid, input logic eWrErr, input logic eRdErr);
    vec_t v;
    v.wr = wr; v.rd = rd; v.din = din; v.eData = eData; v.eCount = eCount;
    v.eValid = eValid; v.eWrErr = eWrErr; v.eRdErr = eRdErr;
    vecs.push_back(v);
  endtask

  // Reference model: applies the acceptance rules to a queue, then checks.
  task automatic modelStep(input string tag, input logic wr, input logic rd, input logic [63:0] din);
    bit rAcc, wAcc, eValid, eWE, eRE;
    rAcc = rd && (modelQ.size() > 0);
    wAcc = wr && ((modelQ.size() < DEPTH) || rAcc);
    if (rAcc) modelData = modelQ.pop_front();
    if (wAcc) modelQ.push_back(din);
    eValid = rAcc;
    eWE = wr && !wAcc;
    eRE = rd && !rAcc;
    step(wr, rd, din);
    chkAll(tag, modelData, modelQ.size(), eValid, eWE, eRE);
  endtask

  task automatic doReset();
    reset = 1'b1;
    #7;
    reset = 1'b0;
    @(posedge clk);
    #1;
    modelQ.delete();
    modelData = 64'h0;
  endtask

  initial begin
    // Directed table: fill, overflow, full read+write, drain, underflow,
    // write+read on empty, then a plain fill/drain ending in underflow.
    addVec(1, 0, 64'hA1, 64'h0,  1, 0, 0, 0);
    addVec(1, 0, 64'hA2, 64'h0,  2, 0, 0, 0);
    addVec(1, 0, 64'hA3, 64'h0,  3, 0, 0, 0);
    addVec(1, 0, 64'hA4, 64'h0,  4, 0, 0, 0);
    addVec(1, 0, 64'hA5, 64'h0,  4, 0, 1, 0);
    addVec(1, 1, 64'hB1, 64'hA1, 4, 1, 0, 0);
    addVec(0, 1, 64'h0,  64'hA2, 3, 1, 0, 0);
    addVec(0, 1, 64'h0,  64'hA3, 2, 1, 0, 0);
    addVec(0, 1, 64'h0,  64'hA4, 1, 1, 0, 0);
    addVec(0, 1, 64'h0,  64'hB1, 0, 1, 0, 0);
    addVec(0, 1, 64'h0,  64'hB1, 0, 0, 0, 1);
    addVec(1, 1, 64'hC1, 64'hB1, 1, 0, 0, 1);
    addVec(0, 1, 64'h0,  64'hC1, 0, 1, 0, 0);
    addVec(0, 0, 64'h0,  64'hC1, 0, 0, 0, 0);
    addVec(1, 0, 64'hA1, 64'hC1, 1, 0, 0, 0);
    addVec(1, 0, 64'hA2, 64'hC1, 2, 0, 0, 0);
    addVec(1, 0, 64'hA3, 64'hC1, 3, 0, 0, 0);
    addVec(1, 0, 64'hA4, 64'hC1, 4, 0, 0, 0);
    addVec(0, 1, 64'h0,  64'hA1, 3, 1, 0, 0);
    addVec(0, 1, 64'h0,  64'hA2, 2, 1, 0, 0);
    addVec(0, 1, 64'h0,  64'hA3, 1, 1, 0, 0);
    addVec(0, 1, 64'h0,  64'hA4, 0, 1, 0, 0);
    addVec(0, 1, 64'h0,  64'hA4, 0, 0, 0, 1);

    // Reset state, checked while reset is still asserted.
    #2;
    chkAll("resetState", 64'h0, 0, 0, 0, 0);
    #5;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chkAll("afterRelease", 64'h0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].wr, vecs[i].rd, vecs[i].din);
      chkAll($sformatf("vec%0d", i), vecs[i].eData, vecs[i].eCount,
             vecs[i].eValid, vecs[i].eWrErr, vecs[i].eRdErr);
    end

    // Asynchronous reset mid-operation with three entries stored.
    step(1, 0, 64'hE1);
    step(1, 0, 64'hE2);
    step(1, 0, 64'hE3);
    chk("preReset.count", 64'(count), 64'd3);
    #2;
    reset = 1'b1;
    #1;
    chkAll("asyncReset", 64'h0, 0, 0, 0, 0);
    wrEnable = 1'b1;
    rdEnable = 1'b1;
    dataIn   = 64'hEE;
    @(posedge clk);
    #1;
    chkAll("reqDuringReset", 64'h0, 0, 0, 0, 0);
    wrEnable = 1'b0;
    rdEnable = 1'b0;
    #2;
    reset = 1'b0;
    step(0, 1, 64'h0);
    chkAll("noStaleRead", 64'h0, 0, 0, 0, 1);
    step(1, 0, 64'hD1);
    chkAll("postResetWrite", 64'h0, 1, 0, 0, 0);
    step(0, 1, 64'h0);
    chkAll("postResetRead", 64'hD1, 0, 1, 0, 0);

    // Alternating write/read, wrapping the pointers several times.
    doReset();
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) modelStep($sformatf("alt%0d", i), 1'b1, 1'b0, 64'h100 + 64'(i));
      else            modelStep($sformatf("alt%0d", i), 1'b0, 1'b1, 64'h0);
      chk($sformatf("alt%0d.countMax", i), 64'(count <= 3'd1), 64'd1);
    end

    // Randomized traffic against the queue model, with an occasional reset.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) doReset();
      modelStep($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                {$urandom, $urandom});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
